// File: rtl/led_blink_mon_if.sv
// Result/acknowledge bus of led_blink_mon: the monitor drives the measurement,
// the consumer drives the acknowledge.
interface led_blink_mon_if #(
  parameter int unsigned CNT_W = 32
);
  logic             rd_i;
  logic [CNT_W-1:0] half_period_o;
  logic [4:0]       div_est_o;
  logic             period_valid_o;
  logic             overrun_o;
  logic             stuck_o;

  modport master (
    input  rd_i,
    output half_period_o, div_est_o, period_valid_o, overrun_o, stuck_o
  );

  modport slave (
    output rd_i,
    input  half_period_o, div_est_o, period_valid_o, overrun_o, stuck_o
  );
endinterface

// File: rtl/led_blink_mon.sv
// LED blink-period monitor: times clk100 cycles between LED toggles and reports them.
// Optional glitch filter on the synchronised level is enabled by LED_MON_FILTER_EN.
//
// state     | meaning
// WAIT_EDGE | after reset; first edge only arms the measurement
// MEASURE   | timing edge-to-edge intervals, each edge reports a result
// STUCK     | no edge for TIMEOUT cycles; counter frozen, next edge re-arms
module led_blink_mon #(
  parameter int unsigned      CNT_W    = 32,
  parameter logic [CNT_W-1:0] TIMEOUT  = CNT_W'(2**26),
  parameter int unsigned      FILT_LEN = 4
) (
  input  logic             clk100,
  input  logic             rstn,
  input  logic             led_i,
  led_blink_mon_if.master  bus
);

  typedef enum logic [1:0] {
    WAIT_EDGE = 2'd0,
    MEASURE   = 2'd1,
    STUCK     = 2'd2
  } state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic             lvl;
  logic             edge_det;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] ival;

  logic [CNT_W-1:0] half_q;
  logic [4:0]       div_q;
  logic             valid_q;
  logic             overrun_q;
  logic             stuck_q;

  function automatic logic [4:0] msb_idx(input logic [CNT_W-1:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < CNT_W; i++) begin
      if (v[i]) r = 5'(i);
    end
    return r;
  endfunction

  always_ff @(posedge clk100) begin
    if (!rstn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= led_i;
      s2 <= s1;
      s3 <= lvl;
    end
  end

`ifdef LED_MON_FILTER_EN
  localparam int unsigned   FW      = $clog2(FILT_LEN + 1);
  localparam logic [FW-1:0] FILT_TC = FW'(FILT_LEN - 1);

  logic          filt;
  logic [FW-1:0] filt_tmr;

  // The filtered level follows s2 only after FILT_LEN consecutive differing samples.
  always_ff @(posedge clk100) begin
    if (!rstn) begin
      filt     <= 1'b0;
      filt_tmr <= FILT_TC;
    end else if (s2 == filt) begin
      filt_tmr <= FILT_TC;
    end else if (filt_tmr == '0) begin
      filt     <= s2;
      filt_tmr <= FILT_TC;
    end else begin
      filt_tmr <= filt_tmr - 1'b1;
    end
  end

  assign lvl = filt;
`else
  assign lvl = s2;
`endif

  assign edge_det = (lvl != s3);
  assign ival     = (&cnt) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk100) begin
    if (!rstn) begin
      state     <= WAIT_EDGE;
      cnt       <= '0;
      half_q    <= '0;
      div_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      if (bus.rd_i && valid_q) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
      case (state)
        WAIT_EDGE: begin
          if (edge_det) begin
            cnt   <= '0;
            state <= MEASURE;
          end else begin
            cnt <= ival;
          end
        end
        MEASURE: begin
          if (edge_det) begin
            cnt     <= '0;
            half_q  <= ival;
            div_q   <= msb_idx(ival);
            valid_q <= 1'b1;
            // A simultaneous acknowledge counts as reading the old result.
            if (valid_q && !bus.rd_i) overrun_q <= 1'b1;
          end else if (ival == TIMEOUT) begin
            cnt     <= ival;
            stuck_q <= 1'b1;
            state   <= STUCK;
          end else begin
            cnt <= ival;
          end
        end
        STUCK: begin
          if (edge_det) begin
            cnt     <= '0;
            stuck_q <= 1'b0;
            state   <= MEASURE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= WAIT_EDGE;
        end
      endcase
    end
  end

  assign bus.half_period_o  = half_q;
  assign bus.div_est_o      = div_q;
  assign bus.period_valid_o = valid_q;
  assign bus.overrun_o      = overrun_q;
  assign bus.stuck_o        = stuck_q;

endmodule

// File: tb/tb_led_blink_mon.sv
// Bench for led_blink_mon: directed boundary checks followed by random toggle
// gaps scored against an interval model through a result queue.
`timescale 1ns/1ps
module tb_led_blink_mon;

  localparam int CNT_W     = 32;
  localparam int TIMEOUT_C = 1000;
  localparam int FILT_LEN  = 4;
`ifdef LED_MON_FILTER_EN
  localparam int LAT     = 3 + FILT_LEN;
  localparam int MIN_GAP = FILT_LEN + 1;
`else
  localparam int LAT     = 3;
  localparam int MIN_GAP = 1;
`endif

  logic clk100 = 1'b0;
  logic rstn   = 1'b0;
  logic led    = 1'b0;

  led_blink_mon_if #(.CNT_W(CNT_W)) bus ();

  led_blink_mon #(
    .CNT_W   (CNT_W),
    .TIMEOUT (CNT_W'(TIMEOUT_C)),
    .FILT_LEN(FILT_LEN)
  ) dut (
    .clk100(clk100),
    .rstn  (rstn),
    .led_i (led),
    .bus   (bus)
  );

  always #5 clk100 = ~clk100;

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  int sb[$];

  int g, gap_prev, e;
  bit armed, exp_stuck;
  int fixed_gaps[8];

  task automatic cyc(input int n);
    repeat (n) @(negedge clk100);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int log2f(input int x);
    int r = 0;
    while (x > 1) begin
      x = x >> 1;
      r++;
    end
    return r;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_half"},    64'(bus.half_period_o),  0);
    chk({tag, "_div"},     64'(bus.div_est_o),      0);
    chk({tag, "_valid"},   64'(bus.period_valid_o), 0);
    chk({tag, "_overrun"}, 64'(bus.overrun_o),      0);
    chk({tag, "_stuck"},   64'(bus.stuck_o),        0);
  endtask

  task automatic ack();
    bus.rd_i = 1'b1;
    cyc(1);
    bus.rd_i = 1'b0;
  endtask

  // Scoreboard monitor: acknowledges every result, so each negedge with valid
  // high presents a fresh result.
  initial begin
    forever begin
      @(negedge clk100);
      if (mon_en) begin
        if (bus.period_valid_o) begin
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected: got half %0d expected no result", bus.half_period_o);
          end else begin
            e = sb.pop_front();
            chk("sb_half",    64'(bus.half_period_o), 64'(e));
            chk("sb_div",     64'(bus.div_est_o),     64'(log2f(e)));
            chk("sb_overrun", 64'(bus.overrun_o),     0);
          end
          bus.rd_i = 1'b1;
        end else begin
          bus.rd_i = 1'b0;
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rd_i = 1'b0;
    fixed_gaps = '{1, 1, 2, 3, TIMEOUT_C, TIMEOUT_C + 1, 5, TIMEOUT_C - 1};

    cyc(3);
    chk_zero("reset");
    rstn = 1'b1;
    cyc(5);

    led = 1'b1; cyc(LAT);
    chk("first_edge_valid", 64'(bus.period_valid_o), 0);
    cyc(100 - LAT);
    led = 1'b0; cyc(LAT - 1);
    chk("valid_early", 64'(bus.period_valid_o), 0);
    cyc(1);
    chk("p100_half",    64'(bus.half_period_o),  100);
    chk("p100_div",     64'(bus.div_est_o),      6);
    chk("p100_valid",   64'(bus.period_valid_o), 1);
    chk("p100_overrun", 64'(bus.overrun_o),      0);
    cyc(50 - LAT);

    led = 1'b1; cyc(LAT);
    chk("ovr_half",    64'(bus.half_period_o),  50);
    chk("ovr_div",     64'(bus.div_est_o),      5);
    chk("ovr_valid",   64'(bus.period_valid_o), 1);
    chk("ovr_overrun", 64'(bus.overrun_o),      1);
    ack();
    chk("ack_valid",   64'(bus.period_valid_o), 0);
    chk("ack_overrun", 64'(bus.overrun_o),      0);
    ack();
    chk("rd_idle_valid", 64'(bus.period_valid_o), 0);
    chk("rd_idle_half",  64'(bus.half_period_o),  50);
    cyc(40 - LAT - 2);

    led = 1'b0; cyc(LAT);
    chk("p40_half",    64'(bus.half_period_o),  40);
    chk("p40_valid",   64'(bus.period_valid_o), 1);
    cyc(60 - LAT);
    led = 1'b1; cyc(LAT - 1);
    bus.rd_i = 1'b1; cyc(1); bus.rd_i = 1'b0;
    chk("rdcap_half",    64'(bus.half_period_o),  60);
    chk("rdcap_div",     64'(bus.div_est_o),      5);
    chk("rdcap_valid",   64'(bus.period_valid_o), 1);
    chk("rdcap_overrun", 64'(bus.overrun_o),      0);
    ack();

`ifdef LED_MON_FILTER_EN
    cyc(50 - LAT - 1);
    led = 1'b0; cyc(2); led = 1'b1;
    cyc(47);
    chk("glitch_no_valid", 64'(bus.period_valid_o), 0);
    cyc(1);
    led = 1'b0; cyc(LAT);
    chk("glitch_half",  64'(bus.half_period_o),  100);
    chk("glitch_valid", 64'(bus.period_valid_o), 1);
    ack();
`endif

    // Last toggle is LAT+1 cycles back; hold the level into timeout.
    cyc(TIMEOUT_C - 2);
    chk("stuck_early", 64'(bus.stuck_o), 0);
    cyc(1);
    chk("stuck_set",      64'(bus.stuck_o),        1);
    chk("stuck_no_valid", 64'(bus.period_valid_o), 0);
    cyc(200);
    led = ~led; cyc(LAT);
    chk("unstuck_stuck", 64'(bus.stuck_o),        0);
    chk("unstuck_valid", 64'(bus.period_valid_o), 0);
    cyc(20 - LAT);
    led = ~led; cyc(LAT);
    chk("p20_half",  64'(bus.half_period_o),  20);
    chk("p20_div",   64'(bus.div_est_o),      4);
    chk("p20_valid", 64'(bus.period_valid_o), 1);
    cyc(10);

    rstn = 1'b0; led = 1'b0; cyc(1);
    chk_zero("rst_mid");
    rstn = 1'b1; cyc(5);
    led = 1'b1; cyc(LAT);
    chk("rst_first_edge", 64'(bus.period_valid_o), 0);
    cyc(30 - LAT);
    led = 1'b0; cyc(LAT);
    chk("p30_half",  64'(bus.half_period_o),  30);
    chk("p30_valid", 64'(bus.period_valid_o), 1);
    ack();

    // Random phase: model reports every gap up to TIMEOUT; a longer gap
    // raises stuck and yields no report.
    rstn = 1'b0; led = 1'b0; cyc(2);
    rstn = 1'b1;
    mon_en = 1'b1;
    cyc(5);
    armed = 1'b0;
    gap_prev = 0;
    for (int i = 0; i < 60; i++) begin
      led = ~led;
      if (!armed) begin
        armed = 1'b1;
        exp_stuck = 1'b0;
      end else if (gap_prev <= TIMEOUT_C) begin
        sb.push_back(gap_prev);
        exp_stuck = 1'b0;
      end else begin
        exp_stuck = 1'b1;
      end
      if (i < 8) begin
        g = fixed_gaps[i];
      end else begin
        case ($urandom_range(0, 19))
          0:       g = int'($urandom_range(TIMEOUT_C - 1, TIMEOUT_C + 1));
          1:       g = int'($urandom_range(TIMEOUT_C + 2, 1500));
          2:       g = MIN_GAP;
          default: g = int'($urandom_range(MIN_GAP, 300));
        endcase
      end
      if (g < MIN_GAP) g = MIN_GAP;
      if (g >= LAT) begin
        cyc(LAT - 1);
        chk("rand_stuck", 64'(bus.stuck_o), 64'(exp_stuck));
        cyc(g - LAT + 1);
      end else begin
        cyc(g);
      end
      gap_prev = g;
    end
    cyc(LAT + 5);
    chk("sb_drain", 64'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/led_blink_mon.md
# led_blink_mon

Measures the blink period of an LED drive signal by timing the clk100 cycles between its toggles. It is the observer for the LED counter that sits beside the block-design wrapper: it turns the toggling output back into a half-period count and a divider estimate. The result is presented on a valid/acknowledge register interface, and a stuck-LED condition is flagged. It sits in the top-level IO wrapper on the clk100 domain, alongside the LED counter.

## Interface
- CNT_W, 32: width of the cycle counter and of half_period_o (min 8).
- TIMEOUT, 2**26: cycles without an edge before stuck_o asserts (must be < 2**CNT_W).
- FILT_LEN, 4: stable-sample count for the glitch filter (only with LED_MON_FILTER_EN).
- clk100  in  1  system clock; sole clock of the block.
- rstn  in  1  reset; synchronous, active-low.
- led_i  in  1  monitored LED level; may be asynchronous; double-flop synchronised internally.
- rd_i  in  1  acknowledge; clears period_valid_o.
- half_period_o  out  CNT_W  last measured edge-to-edge interval in clk100 cycles.
- div_est_o  out  5  index of highest set bit of half_period_o (0 if half_period_o is 0).
- period_valid_o  out  1  result available; held until acknowledged.
- overrun_o  out  1  sticky; a new result overwrote an unacknowledged one.
- stuck_o  out  1  no edge for TIMEOUT cycles.

## Operation
- Synchroniser s1→s2, delayed copy s3. An edge is detected when s2 != s3.
- Counter cnt: cleared to 0 on a detected edge, otherwise incremented, saturating at all-ones. The measured interval is cnt+1, saturated.
- FSM states:
  - WAIT_EDGE (reset state): first edge → MEASURE; no result is reported.
  - MEASURE: on an edge, capture the interval, recompute div_est_o, set period_valid_o. If period_valid_o was already set and rd_i is low in that cycle, set overrun_o. If cnt+1 reaches TIMEOUT with no edge → STUCK, stuck_o=1.
  - STUCK: counter frozen. On an edge, stuck_o=0, cnt=0, → MEASURE; the timed-out interval is not reported.
- rd_i clears period_valid_o and overrun_o.
- If rd_i and a capture occur in the same cycle, the capture wins: period_valid_o stays 1, the new data is loaded, and overrun_o is cleared (the old result counts as read).
- rd_i while period_valid_o=0 has no effect.
- Reset values: half_period_o=0, div_est_o=0, period_valid_o=0, overrun_o=0, stuck_o=0, state WAIT_EDGE, cnt=0, s1/s2/s3=0.
- Reset mid-measurement discards the partial count.
- Because the synchroniser resets to 0, a led_i held at 1 through reset produces one edge after reset release. That edge only arms MEASURE.

## Timing
- led_i change to edge detect: edge detected in the cycle after the 2nd sampling clk100 edge.
- led_i change to outputs: all outputs update on the 3rd clk100 rising edge, counting the first edge that samples the new level as edge 1.
- rd_i takes effect on the next rising edge: period_valid_o is low one cycle after rd_i is sampled high.
- stuck_o rises on the rising edge at which cnt+1 == TIMEOUT in MEASURE.
- Minimum resolvable half period: 1 cycle without the filter.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- LED_MON_FILTER_EN defined:
  - s2 must hold a new level for FILT_LEN consecutive cycles before the filtered level (which replaces s2 in edge detection) changes.
  - Adds FILT_LEN cycles of latency to each edge.
  - Pulses shorter than FILT_LEN cycles are ignored and do not reset cnt.
  - Intervals are still measured between filtered edges.
- Undefined: no filter. FILT_LEN is ignored, and edge detection uses s2 directly.

## Test plan
- Reset, then toggle led_i every 100 cycles with TIMEOUT=1000. First edge → no valid. Second edge → half_period_o=100, div_est_o=6, period_valid_o=1 on the 3rd clock after the toggle.
- Leave a result unacknowledged and let the next toggle arrive (period 50) → half_period_o=50, div_est_o=5, overrun_o=1. Pulse rd_i → period_valid_o=0 and overrun_o=0 next cycle.
- Assert rd_i in the exact capture cycle → period_valid_o stays 1, new data loaded, overrun_o=0.
- Hold led_i constant for 1000 cycles after an edge (TIMEOUT=1000) → stuck_o=1 at cnt+1=1000. Next edge → stuck_o=0 with no new valid. Following edge 20 cycles later → half_period_o=20.
- Drive rstn low for 1 cycle mid-interval → all outputs 0 on the next edge and state WAIT_EDGE. The next two edges 30 apart → half_period_o=30.
- With LED_MON_FILTER_EN and FILT_LEN=4, inject a 2-cycle glitch between toggles at period 100 → no capture from the glitch, and the next report still reads half_period_o=100.
